// File: rtl/kap_arb_pkg.sv
// Shared definitions for the kap issue arbiter: FSM state encodings and the
// width helper used to size the grant index.
package kap_arb_pkg;

    typedef logic [1:0] kap_state_t;

    localparam kap_state_t ST_IDLE  = 2'd0;
    localparam kap_state_t ST_ISSUE = 2'd1;
    localparam kap_state_t ST_DONE  = 2'd2;

    // Bits needed to index n items; bounded loop so it elaborates as a constant.
    function automatic int kap_clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/kap_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after
// ptr (wrapping modulo NREQ) wins.
module kap_rr_pick
    import kap_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int SRC_W = kap_clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SRC_W-1:0] ptr,
    output logic             valid,
    output logic [SRC_W-1:0] idx
);

    int               pos;
    logic [SRC_W-1:0] pos_idx;

    // Scan from the farthest slot back to ptr so the closest request is written last.
    always_comb begin
        valid   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            pos_idx = SRC_W'(pos);
            if (req[pos_idx]) begin
                valid = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/kap_issue_arb.sv
// Round-robin arbiter and issue sequencer sharing one kap control fork among
// NREQ requesters, with per-transaction timeout supervision and a done count.
module kap_issue_arb
    import kap_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CFG_W = 32,
    parameter int TMO_W = 16,
    parameter int CNT_W = 16,
    localparam int SRC_W = kap_clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NREQ-1:0]       r_req,
    input  logic [NREQ*CFG_W-1:0] r_cfg,
    output logic [NREQ-1:0]       r_ack,
    output logic                  o_kap_req,
    input  logic                  o_kap_ack,
    output logic [CFG_W-1:0]      o_kap_cfg,
    output logic [SRC_W-1:0]      o_kap_src,
    input  logic [TMO_W-1:0]      tmo_limit,
    input  logic                  err_clr,
    output logic                  err_tmo,
    output logic [SRC_W-1:0]      err_src,
    output logic                  busy,
    output logic [CNT_W-1:0]      txn_cnt
);

    kap_state_t       state;
    logic [SRC_W-1:0] ptr;
    logic [TMO_W-1:0] tmo_cnt;
    logic             pick_valid;
    logic [SRC_W-1:0] pick_idx;
    logic [CFG_W-1:0] pick_cfg;
    logic             tmo_event;
    logic [SRC_W-1:0] ptr_next;

    kap_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (r_req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_cfg = r_cfg[pick_idx*CFG_W +: CFG_W];
    end

    always_comb begin
        if (o_kap_src == SRC_W'(NREQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = o_kap_src + SRC_W'(1);
        end
    end

    // Timeout is reporting only: the fork request is never withdrawn early.
    always_comb begin
        tmo_event = (state == ST_ISSUE) && (tmo_limit != '0) && !o_kap_ack &&
                    (tmo_cnt == tmo_limit - TMO_W'(1));
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            o_kap_req <= 1'b0;
            o_kap_cfg <= '0;
            o_kap_src <= '0;
            r_ack     <= '0;
            ptr       <= '0;
            tmo_cnt   <= '0;
        end else begin
            r_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (en && pick_valid) begin
                        state     <= ST_ISSUE;
                        o_kap_req <= 1'b1;
                        o_kap_src <= pick_idx;
                        o_kap_cfg <= pick_cfg;
                        tmo_cnt   <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (o_kap_ack) begin
                        state     <= ST_DONE;
                        o_kap_req <= 1'b0;
                        r_ack     <= NREQ'(1) << o_kap_src;
                    end
                    if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ptr   <= ptr_next;
                end
                default: begin
                    state     <= ST_IDLE;
                    o_kap_req <= 1'b0;
                end
            endcase
        end
    end

    // A timeout in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_tmo <= 1'b0;
            err_src <= '0;
        end else if (tmo_event) begin
            err_tmo <= 1'b1;
            if (!err_tmo) begin
                err_src <= o_kap_src;
            end
        end else if (err_clr) begin
            err_tmo <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txn_cnt <= '0;
        end else if (state == ST_DONE) begin
            txn_cnt <= txn_cnt + CNT_W'(1);
        end
    end

    a_req_matches_issue: assert property (@(posedge clk) o_kap_req == (state == ST_ISSUE));
    a_ack_onehot: assert property (@(posedge clk) $onehot0(r_ack));

endmodule

// File: doc/kap_issue_arb.md
# kap_issue_arb

Round-robin arbiter and issue sequencer that shares one kap control fork (the select-in / permute-in / vmem / permute-out / select-out fan-out) between NREQ requesters. It grants one requester at a time and holds that requester's configuration word stable for the whole transaction. It drives the fork's single req/ack pair and returns a registered one-cycle ack to the winner. It also supervises each transaction with an optional timeout and keeps a completed-transaction count.

## Interface
- NREQ, 4, number of requesters (2..16)
- CFG_W, 32, configuration word width forwarded to the datapath
- TMO_W, 16, timeout counter / limit width
- CNT_W, 16, completed-transaction counter width
- SRC_W, derived as clog2(NREQ), grant index width
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- en  in  1  1 = new grants allowed; 0 = finish current transaction, then idle
- r_req  in  NREQ  per-requester request level
- r_cfg  in  NREQ*CFG_W  per-requester config; slice i = bits [i*CFG_W +: CFG_W]
- r_ack  out  NREQ  one-hot, one-cycle completion pulse
- o_kap_req  out  1  request to kap control fork
- o_kap_ack  in  1  fork completion; valid only while o_kap_req=1
- o_kap_cfg  out  CFG_W  latched config of the granted requester
- o_kap_src  out  SRC_W  granted requester index
- tmo_limit  in  TMO_W  cycles allowed in ISSUE; 0 disables the timeout
- err_clr  in  1  clears err_tmo
- err_tmo  out  1  sticky timeout flag
- err_src  out  SRC_W  requester index at first timeout since last clear
- busy  out  1  state != IDLE
- txn_cnt  out  CNT_W  completed transactions, wraps modulo 2^CNT_W

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: if en=1 and any r_req is set, pick the winner with rotating priority starting at ptr. Register grant index g to o_kap_src and r_cfg[g] to o_kap_cfg, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: o_kap_req=1. o_kap_cfg and o_kap_src are held constant. On o_kap_ack=1, go to DONE. The tmo counter increments each ISSUE cycle and is cleared on entry to ISSUE.
- DONE: r_ack[g]=1 for exactly this cycle. ptr <= (g+1) mod NREQ; txn_cnt += 1. Next state is IDLE.
- Requester rule: hold r_req and r_cfg stable until r_ack. If r_req is still high in the cycle after r_ack, that is a new request.
- Fork rule: o_kap_req is never withdrawn before o_kap_ack, because the fork's per-branch ack flops require this. A timeout is therefore reporting only.
- Timeout: when tmo_limit!=0, state=ISSUE and the counter reaches tmo_limit-1 without ack, set err_tmo. err_src is loaded only if err_tmo was 0. The transaction keeps waiting. The counter saturates and does not wrap.
- If err_clr and a new timeout event occur in the same cycle, the set wins.
- en drop during ISSUE/DONE: the current transaction completes normally, and no new grant is made.
- r_req[g] dropping during ISSUE is a protocol violation. The arbiter ignores it and completes the transaction.
- An ack with o_kap_req=0 is ignored.

## Timing
- Reset values: state IDLE, o_kap_req 0, r_ack 0, o_kap_cfg 0, o_kap_src 0, ptr 0, err_tmo 0, err_src 0, busy 0, txn_cnt 0, tmo counter 0.
- Grant latency: r_req sampled in IDLE at cycle N gives o_kap_req=1 at N+1.
- Ack latency: o_kap_ack at cycle K gives r_ack at K+1 and IDLE at K+2.
- Back-to-back: at best one transaction per 3 cycles. With a same-cycle ack: ISSUE at N+1, DONE at N+2, IDLE at N+3.
- All outputs are registered except busy, which is decoded from the state register.
- Reset in any state: everything returns to reset values on the next edge and o_kap_req drops. The fork must be reset in the same cycle (system-level rule).

## Structure
- Package kap_arb_pkg holds the state enum (IDLE/ISSUE/DONE) and the clog2 constant function for SRC_W.
- Sub-module kap_rr_pick: combinational rotating-priority picker. Inputs are req[NREQ] and ptr. Outputs are a valid flag and an index. It is instantiated once.
- Top level holds the FSM, the cfg/src capture registers, the timeout counter, error capture and txn_cnt.

## Test plan
- Single requester: r_req=0001, r_cfg[0]=0xA5A5_0001, fork acks 3 cycles after o_kap_req rises. Expect o_kap_cfg=0xA5A5_0001, o_kap_src=0, r_ack=0001 exactly one cycle after the ack, txn_cnt=1.
- Fairness: r_req=1111 held continuously, ack same cycle. Expect grant order 0,1,2,3,0, a 3-cycle issue period, and txn_cnt=5 after 15 cycles.
- Config stability: change r_cfg[g] during ISSUE. Expect o_kap_cfg unchanged until DONE.
- Timeout: tmo_limit=4, no ack for 10 cycles. Expect err_tmo set at the 4th ISSUE cycle, err_src=g, and o_kap_req still 1. Ack later completes normally. err_clr drops err_tmo. tmo_limit=0 never flags.
- en gating: en=0 while in ISSUE with r_req=0110. Expect the current transaction to finish, then no grant. Raising en grants the next index after ptr.
- Reset mid-ISSUE: assert reset for 1 cycle. Expect o_kap_req=0, busy=0, ptr=0 and txn_cnt=0 on the next edge. A new request is then granted from index 0.
